// File: rtl/captura_operandos.sv
// Keypad front end for the 4-digit BCD adder: builds the live entry and the saved
// operand from key events and issues guardar/suma strobes to the adder.
module captura_operandos #(
  parameter logic [3:0] TECLA_GUARDAR = 4'hA,
  parameter logic [3:0] TECLA_SUMA    = 4'hB,
  parameter logic [3:0] TECLA_BORRAR  = 4'hC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tecla_valida,
  input  logic [3:0]      tecla,
  input  logic            rst_sv,
  output logic [3:0][3:0] numero,
  output logic [3:0][3:0] numero_sv,
  output logic            guardar,
  output logic            suma,
  output logic [2:0]      num_digitos,
  output logic [1:0]      estado_o
);

  typedef enum logic [1:0] {
    CAPTURA_A = 2'd0,
    CAPTURA_B = 2'd1,
    SUMANDO   = 2'd2,
    MOSTRAR   = 2'd3
  } estado_t;

  estado_t         estado, estado_nx;
  logic [3:0][3:0] numero_nx, numero_sv_nx;
  logic [2:0]      num_digitos_nx;
  logic            guardar_nx, suma_nx;
  logic            es_digito;

  assign es_digito = (tecla <= 4'd9);
  assign estado_o  = estado;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= CAPTURA_A;
    end else begin
      estado <= estado_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      numero      <= '0;
      numero_sv   <= '0;
      num_digitos <= '0;
      guardar     <= 1'b0;
      suma        <= 1'b0;
    end else begin
      numero      <= numero_nx;
      numero_sv   <= numero_sv_nx;
      num_digitos <= num_digitos_nx;
      guardar     <= guardar_nx;
      suma        <= suma_nx;
    end
  end

  // rst_sv clears the saved operand by default; a capture below overrides it.
  always_comb begin
    estado_nx      = estado;
    numero_nx      = numero;
    numero_sv_nx   = rst_sv ? '0 : numero_sv;
    num_digitos_nx = num_digitos;
    guardar_nx     = 1'b0;
    suma_nx        = 1'b0;

    unique case (estado)
      CAPTURA_A, CAPTURA_B: begin
        if (tecla_valida) begin
          if (es_digito) begin
            if (num_digitos < 3'd4) begin
              numero_nx      = {numero[2:0], tecla};
              num_digitos_nx = num_digitos + 3'd1;
            end
          end else if (tecla == TECLA_BORRAR) begin
            numero_nx      = '0;
            num_digitos_nx = '0;
          end else if (tecla == TECLA_GUARDAR) begin
            numero_sv_nx   = numero;
            numero_nx      = '0;
            num_digitos_nx = '0;
            guardar_nx     = 1'b1;
            estado_nx      = CAPTURA_B;
          end else if (tecla == TECLA_SUMA && estado == CAPTURA_B) begin
            suma_nx   = 1'b1;
            estado_nx = SUMANDO;
          end
        end
      end
      SUMANDO: begin
        estado_nx = MOSTRAR;
      end
      MOSTRAR: begin
        if (tecla_valida) begin
          if (es_digito) begin
            numero_nx      = {4'h0, 4'h0, 4'h0, tecla};
            numero_sv_nx   = '0;
            num_digitos_nx = 3'd1;
            estado_nx      = CAPTURA_A;
          end else if (tecla == TECLA_BORRAR) begin
            numero_nx      = '0;
            num_digitos_nx = '0;
          end else if (tecla == TECLA_GUARDAR) begin
            guardar_nx = 1'b1;
            estado_nx  = CAPTURA_A;
          end
        end
      end
      default: begin
        estado_nx = CAPTURA_A;
      end
    endcase
  end

endmodule
